// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the alu_seq block.
// The multiply/divide opcodes only execute when ALU_SEQ_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SLL    = 5'b00101;
    localparam logic [4:0] OP_SRL    = 5'b00110;
    localparam logic [4:0] OP_SLT    = 5'b00111;
    localparam logic [4:0] OP_SRA    = 5'b01110;
    localparam logic [4:0] OP_SLTU   = 5'b01111;
    localparam logic [4:0] OP_SLL12  = 5'b10000;

    localparam logic [4:0] OP_MUL    = 5'b11000;
    localparam logic [4:0] OP_MULH   = 5'b11001;
    localparam logic [4:0] OP_MULHSU = 5'b11010;
    localparam logic [4:0] OP_MULHU  = 5'b11011;
    localparam logic [4:0] OP_DIV    = 5'b11100;
    localparam logic [4:0] OP_DIVU   = 5'b11101;
    localparam logic [4:0] OP_REM    = 5'b11110;
    localparam logic [4:0] OP_REMU   = 5'b11111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // All iterative opcodes share the 11xxx prefix.
    function automatic logic is_multicycle(input logic [4:0] op);
        return (op[4:3] == 2'b11);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle of the alu_seq block; the slave side is the ALU.
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      ALU_ctr;
    logic [XLEN-1:0] ALU_srcA;
    logic [XLEN-1:0] ALU_srcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALU_resp;
    logic            busy;

    modport master (
        output in_valid, ALU_ctr, ALU_srcA, ALU_srcB, out_ready,
        input  in_ready, out_valid, ALU_resp, busy
    );

    modport slave (
        input  in_valid, ALU_ctr, ALU_srcA, ALU_srcB, out_ready,
        output in_ready, out_valid, ALU_resp, busy
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative XLEN-step shift-add multiplier / restoring divider for alu_seq.
// Only compiled when ALU_SEQ_MULDIV_EN is defined.
`ifdef ALU_SEQ_MULDIV_EN
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    logic              running_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [4:0]        op_r;
    logic [XLEN-1:0]   a_orig_r;
    logic [XLEN-1:0]   b_r;
    logic [2*XLEN-1:0] p_r;
    logic              neg_lo_r;
    logic              neg_hi_r;
    logic              div0_r;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, is_div_s;
    logic [XLEN-1:0]   a_abs_s, b_abs_s;
    logic [XLEN:0]     mul_sum_s, div_sh_s, div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] mul_next_s, div_next_s, p_next_s, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    // Operand sign handling at the start of an operation.
    always_comb begin
        a_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg_s    = a_signed_s && src_a[XLEN-1];
        b_neg_s    = b_signed_s && src_b[XLEN-1];
        a_abs_s    = a_neg_s ? (~src_a + {{(XLEN-1){1'b0}}, 1'b1}) : src_a;
        b_abs_s    = b_neg_s ? (~src_b + {{(XLEN-1){1'b0}}, 1'b1}) : src_b;
        is_div_s   = op[2];
    end

    // One radix-2 step of either engine; p_r holds {high half, low half}.
    always_comb begin
        mul_sum_s  = {1'b0, p_r[2*XLEN-1:XLEN]} + (p_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        mul_next_s = {mul_sum_s, p_r[XLEN-1:1]};
        div_sh_s   = {p_r[2*XLEN-1:XLEN], p_r[XLEN-1]};
        div_diff_s = div_sh_s - {1'b0, b_r};
        div_ge_s   = ~div_diff_s[XLEN];
        div_next_s = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_sh_s[XLEN-1:0]),
                      p_r[XLEN-2:0], div_ge_s};
        if (op_r[2]) begin
            p_next_s = div_next_s;
        end else begin
            p_next_s = mul_next_s;
        end
    end

    // Sign fix-up and result selection, applied to the final step.
    always_comb begin
        prod_s = neg_lo_r ? (~p_next_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : p_next_s;
        quo_s  = p_next_s[XLEN-1:0];
        rem_s  = p_next_s[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:    result = prod_s[XLEN-1:0];
            OP_MULH:   result = prod_s[2*XLEN-1:XLEN];
            OP_MULHSU: result = prod_s[2*XLEN-1:XLEN];
            OP_MULHU:  result = prod_s[2*XLEN-1:XLEN];
            OP_DIV:    result = div0_r ? {XLEN{1'b1}} :
                                (neg_lo_r ? (~quo_s + {{(XLEN-1){1'b0}}, 1'b1}) : quo_s);
            OP_DIVU:   result = div0_r ? {XLEN{1'b1}} : quo_s;
            OP_REM:    result = div0_r ? a_orig_r :
                                (neg_hi_r ? (~rem_s + {{(XLEN-1){1'b0}}, 1'b1}) : rem_s);
            OP_REMU:   result = div0_r ? a_orig_r : rem_s;
            default:   result = {XLEN{1'b0}};
        endcase
        done = running_r && (cnt_r == CNT_W'(XLEN-1));
    end

    // Operand load on start, then XLEN iterations.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= 5'b00000;
            a_orig_r  <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            p_r       <= {(2*XLEN){1'b0}};
            neg_lo_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            div0_r    <= 1'b0;
        end else if (start) begin
            running_r <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= op;
            a_orig_r  <= src_a;
            b_r       <= is_div_s ? b_abs_s : a_abs_s;
            p_r       <= {{XLEN{1'b0}}, (is_div_s ? a_abs_s : b_abs_s)};
            neg_lo_r  <= a_neg_s ^ b_neg_s;
            neg_hi_r  <= a_neg_s;
            div0_r    <= (src_b == {XLEN{1'b0}});
        end else if (running_r) begin
            p_r       <= p_next_s;
            cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            running_r <= ~done;
        end else begin
            p_r       <= p_r;
            cnt_r     <= cnt_r;
            running_r <= running_r;
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and IDLE/CALC/DONE control.
// Define ALU_SEQ_MULDIV_EN to enable the iterative multiply/divide opcodes.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input logic        clk,
    input logic        reset,
    alu_seq_if.slave   bus
);

    logic [1:0]         state_r, state_nxt_s;
    logic               in_ready_r, out_valid_r;
    logic [XLEN-1:0]    resp_r, single_s, md_result_s;
    logic               accept_s, multi_s, md_done_s;
    logic [SHAMT_W-1:0] shamt_s;

    assign accept_s      = (state_r == ST_IDLE) && bus.in_valid;
    assign shamt_s       = bus.ALU_srcB[SHAMT_W-1:0];
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.ALU_resp  = resp_r;

`ifdef ALU_SEQ_MULDIV_EN
    logic busy_r;

    assign multi_s  = is_multicycle(bus.ALU_ctr);
    assign bus.busy = busy_r;

    alu_seq_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept_s && multi_s),
        .op     (bus.ALU_ctr),
        .src_a  (bus.ALU_srcA),
        .src_b  (bus.ALU_srcB),
        .done   (md_done_s),
        .result (md_result_s)
    );

    // busy mirrors the CALC state one-for-one.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_CALC);
        end
    end
`else
    assign multi_s     = 1'b0;
    assign md_done_s   = 1'b0;
    assign md_result_s = {XLEN{1'b0}};
    assign bus.busy    = 1'b0;
`endif

    // Single-cycle datapath; unknown opcodes yield zero.
    always_comb begin
        single_s = {XLEN{1'b0}};
        case (bus.ALU_ctr)
            OP_ADD:   single_s = bus.ALU_srcA + bus.ALU_srcB;
            OP_SUB:   single_s = bus.ALU_srcA - bus.ALU_srcB;
            OP_AND:   single_s = bus.ALU_srcA & bus.ALU_srcB;
            OP_OR:    single_s = bus.ALU_srcA | bus.ALU_srcB;
            OP_XOR:   single_s = bus.ALU_srcA ^ bus.ALU_srcB;
            OP_SLL:   single_s = bus.ALU_srcA << shamt_s;
            OP_SRL:   single_s = bus.ALU_srcA >> shamt_s;
            OP_SRA:   single_s = XLEN'($signed(bus.ALU_srcA) >>> shamt_s);
            OP_SLT:   single_s = {{(XLEN-1){1'b0}}, ($signed(bus.ALU_srcA) < $signed(bus.ALU_srcB))};
            OP_SLTU:  single_s = {{(XLEN-1){1'b0}}, (bus.ALU_srcA < bus.ALU_srcB)};
            OP_SLL12: single_s = {bus.ALU_srcA[XLEN-13:0], 12'h000};
            default:  single_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = multi_s ? ST_CALC : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (md_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, handshake flags and the held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            resp_r      <= {XLEN{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            if (accept_s && !multi_s) begin
                resp_r <= single_s;
            end else if ((state_r == ST_CALC) && md_done_s) begin
                resp_r <= md_result_s;
            end else begin
                resp_r <= resp_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; multiply/divide expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   seen;

    alu_seq_if #(.XLEN(XLEN)) bus ();

    alu_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bus.ALU_ctr  = op;
        bus.ALU_srcA = a;
        bus.ALU_srcB = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [4:0] op,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] exp);
        issue(op, a, b);
        check({tag, " out_valid"}, XLEN'(bus.out_valid), 32'd1);
        check({tag, " result"}, bus.ALU_resp, exp);
        check({tag, " in_ready_done"}, XLEN'(bus.in_ready), 32'd0);
        check({tag, " busy"}, XLEN'(bus.busy), 32'd0);
        tick();
        check({tag, " in_ready_after"}, XLEN'(bus.in_ready), 32'd1);
        check({tag, " out_valid_after"}, XLEN'(bus.out_valid), 32'd0);
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic run_multi(input string tag, input logic [4:0] op,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [XLEN-1:0] exp);
        int edges;
        int busy_cnt;
        issue(op, a, b);
        edges    = 1;
        busy_cnt = 0;
        while (!bus.out_valid && edges < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            edges++;
        end
        check({tag, " latency"}, XLEN'(edges), 32'd33);
        check({tag, " busy_cycles"}, XLEN'(busy_cnt), 32'd32);
        check({tag, " result"}, bus.ALU_resp, exp);
        check({tag, " busy_done"}, XLEN'(bus.busy), 32'd0);
        tick();
        check({tag, " in_ready_after"}, XLEN'(bus.in_ready), 32'd1);
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.ALU_ctr   = 5'b00000;
        bus.ALU_srcA  = 32'h0;
        bus.ALU_srcB  = 32'h0;
        tick();
        tick();
        check("rst in_ready", XLEN'(bus.in_ready), 32'd1);
        check("rst out_valid", XLEN'(bus.out_valid), 32'd0);
        check("rst busy", XLEN'(bus.busy), 32'd0);
        check("rst resp", bus.ALU_resp, 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst in_ready", XLEN'(bus.in_ready), 32'd1);

        run_single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        run_single("sub", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        run_single("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        run_single("or", OP_OR, 32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011);
        run_single("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        run_single("sll", OP_SLL, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006);
        run_single("srl", OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
        run_single("sra", OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        run_single("slt", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        run_single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        run_single("sll12", OP_SLL12, 32'h0000_0001, 32'h0000_0000, 32'h0000_1000);
        run_single("undef", 5'b01000, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);

`ifdef ALU_SEQ_MULDIV_EN
        run_multi("mul", OP_MUL, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C);
        run_multi("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_multi("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_multi("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run_multi("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_multi("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_multi("divu_0", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF);
        run_multi("remu_0", OP_REMU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007);
        run_multi("div_0", OP_DIV, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF);
        run_multi("rem_0", OP_REM, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9);
        run_multi("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        run_multi("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        run_multi("divu", OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
`else
        run_single("mul_off", OP_MUL, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000);
        run_single("div_off", OP_DIV, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000);
`endif

        // Back-pressure: DONE held while new requests are presented.
        bus.out_ready = 1'b0;
        issue(OP_ADD, 32'h0000_0002, 32'h0000_0003);
        check("bp out_valid", XLEN'(bus.out_valid), 32'd1);
        check("bp result", bus.ALU_resp, 32'h0000_0005);
        for (int i = 0; i < 5; i++) begin
            bus.ALU_ctr  = OP_ADD;
            bus.ALU_srcA = 32'd100;
            bus.ALU_srcB = 32'd100;
            bus.in_valid = 1'b1;
            tick();
            check("bp hold resp", bus.ALU_resp, 32'h0000_0005);
            check("bp hold in_ready", XLEN'(bus.in_ready), 32'd0);
            check("bp hold out_valid", XLEN'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp release in_ready", XLEN'(bus.in_ready), 32'd1);
        check("bp release out_valid", XLEN'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("bp accept out_valid", XLEN'(bus.out_valid), 32'd1);
        check("bp accept result", bus.ALU_resp, 32'd200);
        tick();
        check("bp idle in_ready", XLEN'(bus.in_ready), 32'd1);

        // Reset while a result is pending in DONE, with a competing request.
        bus.out_ready = 1'b0;
        issue(OP_ADD, 32'h0000_0011, 32'h0000_0022);
        check("rst_done pre out_valid", XLEN'(bus.out_valid), 32'd1);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("rst_done out_valid", XLEN'(bus.out_valid), 32'd0);
        check("rst_done resp", bus.ALU_resp, 32'h0);
        check("rst_done in_ready", XLEN'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("rst_done no_result", XLEN'(seen), 32'd0);

`ifdef ALU_SEQ_MULDIV_EN
        // Reset in CALC cycle 10 of a divide must abandon it.
        issue(OP_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        check("rst_calc busy_pre", XLEN'(bus.busy), 32'd1);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.ALU_ctr  = OP_ADD;
        bus.ALU_srcA = 32'd1;
        bus.ALU_srcB = 32'd1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_calc in_ready", XLEN'(bus.in_ready), 32'd1);
        check("rst_calc out_valid", XLEN'(bus.out_valid), 32'd0);
        check("rst_calc busy", XLEN'(bus.busy), 32'd0);
        check("rst_calc resp", bus.ALU_resp, 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid || bus.busy) seen++;
        end
        check("rst_calc no_stale", XLEN'(seen), 32'd0);
`endif

        run_single("final_add", OP_ADD, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width in bits (legal: 16, 32, 64).
REQ-002 The block SHALL have parameter SHAMT_W, default $clog2(XLEN), meaning the shift-amount field width taken from ALU_srcB LSBs.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port ALU_ctr, input, 5 bits: the operation code.
REQ-008 The block SHALL have ports ALU_srcA and ALU_srcB, input, XLEN bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: ALU_resp holds a valid result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port ALU_resp, output, XLEN bits: the registered result.
REQ-012 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.

Function
REQ-013 The block SHALL accept a request on any rising edge where in_valid and in_ready are both high; operands and ALU_ctr SHALL be captured on that edge.
REQ-014 Single-cycle opcodes SHALL be ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110, SLT 00111, SRA 01110, SLTU 01111, and SLL_12 10000 (srcA<<12); shifts SHALL use srcB[SHAMT_W-1:0].
REQ-015 Multi-cycle opcodes SHALL be MUL 11000, MULH 11001, MULHSU 11010, MULHU 11011, DIV 11100, DIVU 11101, REM 11110, and REMU 11111, with RISC-V M-extension semantics at XLEN.
REQ-016 Any undefined opcode SHALL complete as a single-cycle operation with result 0.
REQ-017 The FSM states SHALL be IDLE, CALC, and DONE.
REQ-018 In IDLE, acceptance of a single-cycle op SHALL go to DONE; acceptance of a multi-cycle op SHALL go to CALC.
REQ-019 CALC SHALL run a radix-2 shift-add multiply or restoring divide for exactly XLEN cycles, then go to DONE.
REQ-020 In DONE, out_valid SHALL be 1 and ALU_resp SHALL be stable until out_ready is sampled high, after which the FSM goes to IDLE.
REQ-021 Latency, measured as the number of edges from acceptance to the first out_valid=1, SHALL be 1 for single-cycle ops and XLEN+1 for multi-cycle ops.
REQ-022 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in CALC.
REQ-023 There SHALL be no back-to-back acceptance while DONE is pending.
REQ-024 Operand signs SHALL be taken as absolute values before iteration, and the result sign SHALL be fixed up in the final CALC cycle.
REQ-025 Divide by zero SHALL give DIV/DIVU = all ones and REM/REMU = srcA.
REQ-026 Signed overflow (srcA = most-negative, srcB = -1) SHALL give DIV = srcA and REM = 0.
REQ-027 All arithmetic SHALL wrap modulo 2^XLEN; no flags SHALL be produced.
REQ-028 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-029 On reset high at an edge, the FSM SHALL go to IDLE, out_valid SHALL be 0, busy SHALL be 0, ALU_resp SHALL be 0, and in_ready SHALL be 1 on the next cycle.
REQ-030 Reset in CALC or DONE SHALL abandon the operation, and no result SHALL be produced for it.
REQ-031 Reset SHALL take priority over a simultaneous in_valid.

Configuration
REQ-032 The macro ALU_SEQ_MULDIV_EN SHALL control the multiply/divide feature.
REQ-033 With ALU_SEQ_MULDIV_EN defined, REQ-015 and REQ-019 SHALL apply and the divider sub-module SHALL be instantiated.
REQ-034 Without ALU_SEQ_MULDIV_EN, the opcodes 11000-11111 SHALL be treated as undefined (single-cycle, result 0), CALC SHALL be unreachable, busy SHALL be tied to 0, and no multiply/divide logic SHALL be generated.

Structure
REQ-035 Package alu_pkg SHALL hold the 5-bit opcode constants, the FSM state encoding, and a helper predicate is_multicycle(opcode).
REQ-036 The iterative engine SHALL be sub-module alu_seq_muldiv, with start, operands, op and XLEN inputs and done plus result outputs; the top SHALL keep the FSM, handshake, and single-cycle datapath.

Verification
REQ-037 The bench SHALL check ADD 0x7FFFFFFF + 1 with out_ready tied high -> out_valid on the next cycle, result 0x80000000, in_ready 1 the cycle after.
REQ-038 The bench SHALL check SRA 0x80000000 by srcB 0x24 -> shift of 4 -> result 0xF8000000; SLL_12 of 0x1 -> 0x1000.
REQ-039 The bench SHALL check MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0 and MULHU on the same operands -> 0xFFFFFFFE, with out_valid exactly 33 edges after acceptance and busy high for 32 cycles.
REQ-040 The bench SHALL check DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM on the same operands -> 0, DIVU 7/0 -> 0xFFFFFFFF, and REMU 7/0 -> 7.
REQ-041 The bench SHALL hold out_ready low for 5 cycles after a DONE -> ALU_resp stable, in_ready 0, and new in_valid ignored, then check acceptance on the cycle after out_ready high.
REQ-042 The bench SHALL assert reset at CALC cycle 10 of a DIV -> next cycle IDLE, out_valid 0, and busy 0, and check that no stale result appears; it SHALL also build without ALU_SEQ_MULDIV_EN and check that MUL 3x4 gives 0 in 1 cycle.
